// File: rtl/pipe_dmem_resp.sv
// Data-memory responder for the pipelined CPU's M stage: fixed-latency load/store with a
// one-cycle ready pulse, error flag for illegal addresses and a combinational pipeline stall.
module pipe_dmem_resp #(
    parameter int DEPTH_LOG2 = 5,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ready,
    output logic        err,
    output logic        stall,
    output logic [15:0] acc_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic               we_r;
    logic [31:0]        addr_r;
    logic [31:0]        din_r;
    logic [31:0]        dout_r;
    logic               ready_r;
    logic               err_r;
    logic [15:0]        acc_cnt_r;
    logic [31:0]        mem_r [0:DEPTH-1];

    logic               latch_s;
    logic               access_s;
    logic               acc_we_s;
    logic [31:0]        acc_addr_s;
    logic [31:0]        acc_din_s;
    logic               legal_s;
    logic [DEPTH_LOG2-1:0] idx_s;

    // Word-aligned and inside the memory window.
    function automatic logic addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (DEPTH_LOG2 + 2)) == 32'd0);
    endfunction

    // With LATENCY=1 the access happens on the accepting edge, so the live inputs are used.
    always_comb begin
        if (state_r == IDLE) begin
            acc_we_s   = we;
            acc_addr_s = addr;
            acc_din_s  = din;
        end else begin
            acc_we_s   = we_r;
            acc_addr_s = addr_r;
            acc_din_s  = din_r;
        end
    end

    assign legal_s = addr_legal(acc_addr_s);
    assign idx_s   = acc_addr_s[DEPTH_LOG2+1:2];

    // Next-state and access-edge decode.
    always_comb begin
        state_s  = state_r;
        latch_s  = 1'b0;
        access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    latch_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_s  = RESP;
                        access_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    state_s  = RESP;
                    access_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, latched request and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            we_r      <= 1'b0;
            addr_r    <= 32'd0;
            din_r     <= 32'd0;
            dout_r    <= 32'd0;
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            acc_cnt_r <= 16'd0;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                we_r   <= we;
                addr_r <= addr;
                din_r  <= din;
                cnt_r  <= 4'(LATENCY - 1);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 4'd1;
            end
            ready_r <= access_s;
            err_r   <= access_s & ~legal_s;
            if (access_s && legal_s && !acc_we_s) begin
                dout_r <= mem_r[idx_s];
            end
            if (access_s) begin
                acc_cnt_r <= acc_cnt_r + 16'd1;
            end
        end
    end

    // Storage array; contents survive reset, but reset blocks a pending write.
    always_ff @(posedge clock) begin
        if (!reset && access_s && legal_s && acc_we_s) begin
            mem_r[idx_s] <= acc_din_s;
        end
    end

    assign dout    = dout_r;
    assign ready   = ready_r;
    assign err     = err_r;
    assign acc_cnt = acc_cnt_r;
    assign stall   = req & ~ready_r;

endmodule
